// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage: RV32 ALU decode/issue stage with a single ID/EX slot.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage #(
  parameter int SUPPORT_M = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [3:0]       ALU_Control,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic [31:0]      out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIVU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] shamt;
  logic        unused_rs_fields;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign shamt  = {27'b0, in_instr[24:20]};
  // Register specifiers were already consumed by the register-file read.
  assign unused_rs_fields = ^in_instr[19:15];

  logic        dec_legal;
  logic [3:0]  dec_ctl;
  logic [31:0] dec_b;

  always_comb begin
    dec_legal = 1'b0;
    dec_ctl   = ALU_ADD;
    dec_b     = rs2_data;
    case (opcode)
      OPC_OP: begin
        case (funct7)
          F7_BASE: begin
            dec_legal = 1'b1;
            case (funct3)
              3'b000:  dec_ctl = ALU_ADD;
              3'b001:  dec_ctl = ALU_SLL;
              3'b100:  dec_ctl = ALU_XOR;
              3'b101:  dec_ctl = ALU_SRL;
              3'b110:  dec_ctl = ALU_OR;
              3'b111:  dec_ctl = ALU_AND;
              default: dec_legal = 1'b0;
            endcase
          end
          F7_ALT: begin
            dec_legal = 1'b1;
            case (funct3)
              3'b000:  dec_ctl = ALU_SUB;
              3'b101:  dec_ctl = ALU_SRA;
              default: dec_legal = 1'b0;
            endcase
          end
          F7_MULDIV: begin
            if (SUPPORT_M != 0) begin
              dec_legal = 1'b1;
              case (funct3)
                3'b000:  dec_ctl = ALU_MUL;
                3'b101:  dec_ctl = ALU_DIVU;
                default: dec_legal = 1'b0;
              endcase
            end
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec_b = imm_i;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_ctl = ALU_ADD; end
          3'b100: begin dec_legal = 1'b1; dec_ctl = ALU_XOR; end
          3'b110: begin dec_legal = 1'b1; dec_ctl = ALU_OR;  end
          3'b111: begin dec_legal = 1'b1; dec_ctl = ALU_AND; end
          3'b001: begin
            dec_b = shamt;
            if (funct7 == F7_BASE) begin
              dec_legal = 1'b1;
              dec_ctl   = ALU_SLL;
            end
          end
          3'b101: begin
            dec_b = shamt;
            if (funct7 == F7_BASE) begin
              dec_legal = 1'b1;
              dec_ctl   = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              dec_legal = 1'b1;
              dec_ctl   = ALU_SRA;
            end
          end
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Illegal encodings present neutral operands so the ALU sees a harmless ADD 0,0.
  logic [31:0] a_d, b_d;
  logic [3:0]  ctl_d;
  logic        we_d;

  assign a_d   = dec_legal ? rs1_data : 32'd0;
  assign b_d   = dec_legal ? dec_b    : 32'd0;
  assign ctl_d = dec_legal ? dec_ctl  : ALU_ADD;
  assign we_d  = dec_legal && (in_instr[11:7] != 5'd0);

  logic             valid_q, we_q, illegal_q;
  logic [31:0]      a_q, b_q, pc_q;
  logic [3:0]       ctl_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] count_q;
  logic             accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      ctl_q     <= 4'd0;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
      pc_q      <= 32'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (valid_q && out_ready && !illegal_q) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (accept) begin
        valid_q   <= 1'b1;
        a_q       <= a_d;
        b_q       <= b_d;
        ctl_q     <= ctl_d;
        rd_q      <= in_instr[11:7];
        we_q      <= we_d;
        pc_q      <= in_pc;
        illegal_q <= !dec_legal;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_q;
  assign A           = a_q;
  assign B           = b_q;
  assign ALU_Control = ctl_q;
  assign out_rd      = rd_q;
  assign out_we      = we_q;
  assign out_pc      = pc_q;
  assign out_illegal = illegal_q;
  assign issue_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// tb_alu_issue_stage: directed + randomized bench for alu_issue_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_we, out_illegal;
  logic [31:0] A, B, out_pc, issue_count;
  logic [3:0]  ALU_Control;
  logic [4:0]  out_rd;

  logic        in_ready_nm, out_valid_nm, out_we_nm, out_illegal_nm;
  logic [31:0] A_nm, B_nm, out_pc_nm, issue_count_nm;
  logic [3:0]  ALU_Control_nm;
  logic [4:0]  out_rd_nm;

  always #5 clk = ~clk;

  alu_issue_stage #(.SUPPORT_M(1), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALU_Control(ALU_Control), .out_rd(out_rd), .out_we(out_we),
    .out_pc(out_pc), .out_illegal(out_illegal), .issue_count(issue_count)
  );

  alu_issue_stage #(.SUPPORT_M(0), .CNT_W(32)) u_dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nm),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid_nm), .out_ready(out_ready),
    .A(A_nm), .B(B_nm), .ALU_Control(ALU_Control_nm), .out_rd(out_rd_nm), .out_we(out_we_nm),
    .out_pc(out_pc_nm), .out_illegal(out_illegal_nm), .issue_count(issue_count_nm)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [31:0] cnt;
  } slot_t;

  slot_t mdl [2];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode written as an encoding table: {funct7, funct3, opcode}.
  function automatic slot_t ref_decode(input logic [31:0] ins, input logic [31:0] r1,
                                       input logic [31:0] r2, input bit m);
    slot_t s;
    logic [16:0] key;
    bit ok;
    logic [3:0] c;
    logic [31:0] bv;
    s   = '0;
    key = {ins[31:25], ins[14:12], ins[6:0]};
    ok  = 1'b1;
    c   = 4'h0;
    bv  = r2;
    casez (key)
      17'b0000000_000_0110011: c = 4'b0000;
      17'b0000000_001_0110011: c = 4'b1000;
      17'b0000000_100_0110011: c = 4'b0110;
      17'b0000000_101_0110011: c = 4'b1001;
      17'b0000000_110_0110011: c = 4'b0101;
      17'b0000000_111_0110011: c = 4'b0100;
      17'b0100000_000_0110011: c = 4'b0001;
      17'b0100000_101_0110011: c = 4'b1010;
      17'b0000001_000_0110011: begin c = 4'b0010; ok = m; end
      17'b0000001_101_0110011: begin c = 4'b0011; ok = m; end
      17'b???????_000_0010011: begin c = 4'b0000; bv = 32'(signed'(ins[31:20])); end
      17'b???????_100_0010011: begin c = 4'b0110; bv = 32'(signed'(ins[31:20])); end
      17'b???????_110_0010011: begin c = 4'b0101; bv = 32'(signed'(ins[31:20])); end
      17'b???????_111_0010011: begin c = 4'b0100; bv = 32'(signed'(ins[31:20])); end
      17'b0000000_001_0010011: begin c = 4'b1000; bv = 32'(ins[24:20]); end
      17'b0000000_101_0010011: begin c = 4'b1001; bv = 32'(ins[24:20]); end
      17'b0100000_101_0010011: begin c = 4'b1010; bv = 32'(ins[24:20]); end
      default: ok = 1'b0;
    endcase
    s.valid = 1'b1;
    s.a   = ok ? r1 : 32'd0;
    s.b   = ok ? bv : 32'd0;
    s.ctl = ok ? c : 4'd0;
    s.rd  = ins[11:7];
    s.we  = ok && (ins[11:7] != 5'd0);
    s.ill = !ok;
    return s;
  endfunction

  task automatic model_step(input int k, input bit m, input bit r, input bit v,
                            input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input bit fl, input bit ordy);
    slot_t nxt;
    bit rdy;
    if (r) begin
      mdl[k] = '0;
    end else if (fl) begin
      mdl[k].valid = 1'b0;
      mdl[k].we    = 1'b0;
      mdl[k].ill   = 1'b0;
    end else begin
      rdy = !mdl[k].valid || ordy;
      if (mdl[k].valid && ordy && !mdl[k].ill) mdl[k].cnt = mdl[k].cnt + 1;
      if (v && rdy) begin
        nxt     = ref_decode(ins, r1, r2, m);
        nxt.pc  = pc;
        nxt.cnt = mdl[k].cnt;
        mdl[k]  = nxt;
      end else if (mdl[k].valid && ordy) begin
        mdl[k].valid = 1'b0;
      end
    end
  endtask

  task automatic cmp_slot(input string p, input slot_t e, input logic ov,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                          input logic [3:0] ctl, input logic [4:0] rd, input logic we,
                          input logic ill, input logic [31:0] cnt);
    check_eq({p, "_valid"}, 32'(ov), 32'(e.valid));
    check_eq({p, "_count"}, cnt, e.cnt);
    if (e.valid) begin
      check_eq({p, "_A"}, a, e.a);
      check_eq({p, "_B"}, b, e.b);
      check_eq({p, "_pc"}, pc, e.pc);
      check_eq({p, "_ctl"}, 32'(ctl), 32'(e.ctl));
      check_eq({p, "_rd"}, 32'(rd), 32'(e.rd));
      check_eq({p, "_we"}, 32'(we), 32'(e.we));
      check_eq({p, "_ill"}, 32'(ill), 32'(e.ill));
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input bit fl, input bit ordy);
    rst = r; in_valid = v; in_instr = ins; in_pc = pc;
    rs1_data = r1; rs2_data = r2; flush = fl; out_ready = ordy;
    #1;
    check_eq("in_ready", 32'(in_ready), 32'(!mdl[0].valid || ordy));
    check_eq("in_ready_nm", 32'(in_ready_nm), 32'(!mdl[1].valid || ordy));
    @(posedge clk);
    model_step(0, 1'b1, r, v, ins, pc, r1, r2, fl, ordy);
    model_step(1, 1'b0, r, v, ins, pc, r1, r2, fl, ordy);
    #1;
    cmp_slot("m1", mdl[0], out_valid, A, B, out_pc, ALU_Control, out_rd, out_we,
             out_illegal, issue_count);
    cmp_slot("m0", mdl[1], out_valid_nm, A_nm, B_nm, out_pc_nm, ALU_Control_nm, out_rd_nm,
             out_we_nm, out_illegal_nm, issue_count_nm);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] opc, f7;
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 1, 2: opc = 7'b0110011;
      3, 4, 5: opc = 7'b0010011;
      6:       opc = 7'($urandom);
      default: opc = 7'b0110111;
    endcase
    case ($urandom_range(0, 3))
      0:       f7 = 7'b0000000;
      1:       f7 = 7'b0100000;
      2:       f7 = 7'b0000001;
      default: f7 = 7'($urandom);
    endcase
    return {f7, r[24:20], r[19:15], r[14:12], r[11:7], opc};
  endfunction

  initial begin
    mdl[0] = '0;
    mdl[1] = '0;
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h002081B3, 32'h40, 1, 2, 0, 1);
    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_A", A, 0);
    check_eq("rst_count", issue_count, 0);

    // ADD x3,x1,x2
    cycle(0, 1, 32'h002081B3, 32'h100, 5, 7, 0, 1);
    check_eq("add_A", A, 5);
    check_eq("add_B", B, 7);
    check_eq("add_ctl", 32'(ALU_Control), 0);
    check_eq("add_rd", 32'(out_rd), 3);
    check_eq("add_we", 32'(out_we), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("add_count", issue_count, 1);

    // SRAI x5,x6,4 then ADDI x1,x0,-1 back-to-back
    cycle(0, 1, 32'h40435293, 32'h104, 32'h80000000, 32'h1234, 0, 1);
    check_eq("srai_ctl", 32'(ALU_Control), 32'hA);
    check_eq("srai_B", B, 32'h4);
    cycle(0, 1, 32'hFFF00093, 32'h108, 0, 32'h55, 0, 1);
    check_eq("addi_B", B, 32'hFFFFFFFF);
    check_eq("addi_ctl", 32'(ALU_Control), 0);

    // SUB held under back-pressure, then drain + load on the same edge
    cycle(0, 1, 32'h402081B3, 32'h10C, 9, 4, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 32'h002081B3, 32'h110, 1, 1, 0, 0);
      check_eq("hold_ready", 32'(in_ready), 0);
      check_eq("hold_ctl", 32'(ALU_Control), 1);
    end
    cycle(0, 1, 32'h002081B3, 32'h110, 1, 1, 0, 1);
    check_eq("bp_next_pc", out_pc, 32'h110);
    check_eq("bp_count", issue_count, 4);

    // SLT illegal, MUL legal only with SUPPORT_M
    cycle(0, 1, 32'h0020A1B3, 32'h114, 3, 3, 0, 1);
    check_eq("slt_ill", 32'(out_illegal), 1);
    check_eq("slt_we", 32'(out_we), 0);
    check_eq("slt_ctl", 32'(ALU_Control), 0);
    cycle(0, 1, 32'h022081B3, 32'h118, 3, 3, 0, 1);
    check_eq("slt_count", issue_count, 5);
    check_eq("mul_ctl", 32'(ALU_Control), 2);
    check_eq("mul_nm_ill", 32'(out_illegal_nm), 1);

    // Flush with held instruction and a pending one
    cycle(0, 1, 32'h002081B3, 32'h11C, 1, 2, 0, 0);
    cycle(0, 1, 32'h002081B3, 32'h120, 1, 2, 1, 0);
    check_eq("flush_valid", 32'(out_valid), 0);
    check_eq("flush_we", 32'(out_we), 0);
    check_eq("flush_ill", 32'(out_illegal), 0);
    cycle(0, 1, 32'h00208033, 32'h124, 1, 2, 0, 1);
    check_eq("rd0_we", 32'(out_we), 0);

    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
            $urandom, $urandom, $urandom, ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
